// File: rtl/pump_arbiter_pkg.sv
// Shared state encodings, grant identifiers and fault codes for the two-tank
// pump arbiter.
package pump_arbiter_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OPEN_A = 3'd1;
  localparam logic [2:0] ST_FILL_A = 3'd2;
  localparam logic [2:0] ST_STOP_A = 3'd3;
  localparam logic [2:0] ST_OPEN_B = 3'd4;
  localparam logic [2:0] ST_FILL_B = 3'd5;
  localparam logic [2:0] ST_STOP_B = 3'd6;
  localparam logic [2:0] ST_FAULT  = 3'd7;

  typedef logic [1:0] fault_code_t;

  localparam fault_code_t FC_NONE     = 2'b00;
  localparam fault_code_t FC_TIMEOUT  = 2'b01;
  localparam fault_code_t FC_SENSOR_A = 2'b10;
  localparam fault_code_t FC_SENSOR_B = 2'b11;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/pump_arbiter_debounce.sv
// Level debouncer: the output follows the input only after the input has held
// a new value for DEBOUNCE consecutive cycles.
module level_debounce #(
  parameter int DEBOUNCE = 2000,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;

  // Any cycle where the input agrees with the accepted value restarts the count.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (din != dout_q) begin
      if (cnt_q >= CNT_LAST) begin
        dout_d = din;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/pump_arbiter.sv
// Shares one pump between tanks A and B: debounced level sensing, round-robin
// grant, valve/motor sequencing, fill timeout and sensor-consistency faults.
module pump_arbiter
  import pump_arbiter_pkg::*;
#(
  parameter int DEBOUNCE  = 2000,
  parameter int VALVE_DLY = 500,
  parameter int MAX_FILL  = 60000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       lo_a,
  input  logic       hi_a,
  input  logic       lo_b,
  input  logic       hi_b,
  input  logic       clr_flt,
  output logic       m1,
  output logic       valve_a,
  output logic       valve_b,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [CNT_W-1:0] VALVE_LAST = CNT_W'(VALVE_DLY - 1);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(MAX_FILL - 1);

  logic lo_a_db, hi_a_db, lo_b_db, hi_b_db;

  level_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_db_lo_a (.clk(clk), .rstn(rstn), .din(lo_a), .dout(lo_a_db));
  level_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_db_hi_a (.clk(clk), .rstn(rstn), .din(hi_a), .dout(hi_a_db));
  level_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_db_lo_b (.clk(clk), .rstn(rstn), .din(lo_b), .dout(lo_b_db));
  level_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_db_hi_b (.clk(clk), .rstn(rstn), .din(hi_b), .dout(hi_b_db));

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             last_grant_q, last_grant_d;
  logic             req_a_q, req_a_d, req_b_q, req_b_d;
  fault_code_t      code_q, code_d;
  logic             m1_q, m1_d, valve_a_q, valve_a_d, valve_b_q, valve_b_d;
  logic             busy_q, busy_d, fault_q, fault_d;

  // Sensor consistency outranks every sequencing decision outside FAULT.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    code_d       = code_q;
    if (state_q != ST_FAULT && hi_a_db && !lo_a_db) begin
      state_d = ST_FAULT;
      code_d  = FC_SENSOR_A;
    end else if (state_q != ST_FAULT && hi_b_db && !lo_b_db) begin
      state_d = ST_FAULT;
      code_d  = FC_SENSOR_B;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_a_q && (!req_b_q || last_grant_q == GRANT_B)) state_d = ST_OPEN_A;
          else if (req_b_q)                                     state_d = ST_OPEN_B;
        end
        ST_OPEN_A: if (timer_q >= VALVE_LAST) state_d = ST_FILL_A;
        ST_FILL_A: begin
          if (hi_a_db) state_d = ST_STOP_A;
          else if (timer_q >= FILL_LAST) begin
            state_d = ST_FAULT;
            code_d  = FC_TIMEOUT;
          end
        end
        ST_STOP_A: begin
          if (timer_q >= VALVE_LAST) begin
            state_d      = ST_IDLE;
            last_grant_d = GRANT_A;
          end
        end
        ST_OPEN_B: if (timer_q >= VALVE_LAST) state_d = ST_FILL_B;
        ST_FILL_B: begin
          if (hi_b_db) state_d = ST_STOP_B;
          else if (timer_q >= FILL_LAST) begin
            state_d = ST_FAULT;
            code_d  = FC_TIMEOUT;
          end
        end
        ST_STOP_B: begin
          if (timer_q >= VALVE_LAST) begin
            state_d      = ST_IDLE;
            last_grant_d = GRANT_B;
          end
        end
        ST_FAULT: begin
          if (clr_flt) begin
            state_d = ST_IDLE;
            code_d  = FC_NONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Timer restarts on every state change and saturates instead of wrapping.
  always_comb begin
    if (state_d != state_q)  timer_d = '0;
    else if (&timer_q)       timer_d = timer_q;
    else                     timer_d = timer_q + 1'b1;

    req_a_d = req_a_q | ~lo_a_db;
    if (hi_a_db || (state_d == ST_STOP_A && state_q != ST_STOP_A)) req_a_d = 1'b0;
    req_b_d = req_b_q | ~lo_b_db;
    if (hi_b_db || (state_d == ST_STOP_B && state_q != ST_STOP_B)) req_b_d = 1'b0;

    m1_d      = (state_d == ST_FILL_A) || (state_d == ST_FILL_B);
    valve_a_d = (state_d == ST_OPEN_A) || (state_d == ST_FILL_A) || (state_d == ST_STOP_A);
    valve_b_d = (state_d == ST_OPEN_B) || (state_d == ST_FILL_B) || (state_d == ST_STOP_B);
    busy_d    = valve_a_d | valve_b_d;
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      last_grant_q <= GRANT_B;
      req_a_q      <= 1'b0;
      req_b_q      <= 1'b0;
      code_q       <= FC_NONE;
      m1_q         <= 1'b0;
      valve_a_q    <= 1'b0;
      valve_b_q    <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      req_a_q      <= req_a_d;
      req_b_q      <= req_b_d;
      code_q       <= code_d;
      m1_q         <= m1_d;
      valve_a_q    <= valve_a_d;
      valve_b_q    <= valve_b_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  assign m1         = m1_q;
  assign valve_a    = valve_a_q;
  assign valve_b    = valve_b_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_pump_arbiter.sv
// Directed bench for pump_arbiter with short debounce, valve and fill limits;
// outputs are compared as {m1, valve_a, valve_b, busy, fault, fault_code}.
module tb_pump_arbiter;

  localparam logic [6:0] EXP_IDLE   = 7'b0000000;
  localparam logic [6:0] EXP_VA     = 7'b0101000;
  localparam logic [6:0] EXP_FILL_A = 7'b1101000;
  localparam logic [6:0] EXP_VB     = 7'b0011000;
  localparam logic [6:0] EXP_FILL_B = 7'b1011000;
  localparam logic [6:0] EXP_F_TO   = 7'b0000101;
  localparam logic [6:0] EXP_F_SB   = 7'b0000111;

  typedef struct {
    string      name;
    logic       lo_a;
    logic       hi_a;
    logic       lo_b;
    logic       hi_b;
    int         cycles;
    logic [6:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       lo_a, hi_a, lo_b, hi_b, clr_flt;
  logic       m1, valve_a, valve_b, busy, fault;
  logic [1:0] fault_code;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  pump_arbiter #(
    .DEBOUNCE(4), .VALVE_DLY(3), .MAX_FILL(50), .CNT_W(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .lo_a(lo_a), .hi_a(hi_a), .lo_b(lo_b), .hi_b(hi_b),
    .clr_flt(clr_flt),
    .m1(m1), .valve_a(valve_a), .valve_b(valve_b),
    .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(string name, logic la, logic ha, logic lb, logic hb,
                              int cycles, logic [6:0] exp);
    vec_t v;
    v.name = name; v.lo_a = la; v.hi_a = ha; v.lo_b = lb; v.hi_b = hb;
    v.cycles = cycles; v.exp = exp;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic la, input logic ha, input logic lb, input logic hb);
    lo_a = la; hi_a = ha; lo_b = lb; hi_b = hb;
  endtask

  task automatic check_output(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {m1, valve_a, valve_b, busy, fault, fault_code};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic pulse_clr();
    clr_flt = 1'b1;
    step(1);
    clr_flt = 1'b0;
  endtask

  initial begin
    // Tie after reset, A served first, then B; then a lone tank A fill.
    vecs.push_back(mk("tie_req_latch",   0, 0, 0, 0, 1, EXP_IDLE));
    vecs.push_back(mk("tie_open_a",      0, 0, 0, 0, 1, EXP_VA));
    vecs.push_back(mk("tie_open_a_hold", 0, 0, 0, 0, 2, EXP_VA));
    vecs.push_back(mk("tie_fill_a",      0, 0, 0, 0, 1, EXP_FILL_A));
    vecs.push_back(mk("tie_fill_a_hold", 0, 0, 0, 0, 5, EXP_FILL_A));
    vecs.push_back(mk("tie_a_debounce",  1, 1, 0, 0, 4, EXP_FILL_A));
    vecs.push_back(mk("tie_stop_a",      1, 1, 0, 0, 1, EXP_VA));
    vecs.push_back(mk("tie_stop_a_hold", 1, 1, 0, 0, 2, EXP_VA));
    vecs.push_back(mk("tie_idle_a_done", 1, 1, 0, 0, 1, EXP_IDLE));
    vecs.push_back(mk("tie_open_b",      1, 1, 0, 0, 1, EXP_VB));
    vecs.push_back(mk("tie_fill_b",      1, 1, 0, 0, 3, EXP_FILL_B));
    vecs.push_back(mk("tie_fill_b_hold", 1, 1, 0, 0, 3, EXP_FILL_B));
    vecs.push_back(mk("tie_b_debounce",  1, 1, 1, 1, 4, EXP_FILL_B));
    vecs.push_back(mk("tie_stop_b",      1, 1, 1, 1, 1, EXP_VB));
    vecs.push_back(mk("tie_idle_b_done", 1, 1, 1, 1, 3, EXP_IDLE));
    vecs.push_back(mk("tie_idle_hold",   1, 1, 1, 1, 5, EXP_IDLE));
    vecs.push_back(mk("a_debounce",      0, 0, 1, 1, 5, EXP_IDLE));
    vecs.push_back(mk("a_open",          0, 0, 1, 1, 1, EXP_VA));
    vecs.push_back(mk("a_open_hold",     0, 0, 1, 1, 2, EXP_VA));
    vecs.push_back(mk("a_fill",          0, 0, 1, 1, 1, EXP_FILL_A));
    vecs.push_back(mk("a_fill_hold",     0, 0, 1, 1, 3, EXP_FILL_A));
    vecs.push_back(mk("a_full_debounce", 1, 1, 1, 1, 4, EXP_FILL_A));
    vecs.push_back(mk("a_stop",          1, 1, 1, 1, 1, EXP_VA));
    vecs.push_back(mk("a_stop_hold",     1, 1, 1, 1, 2, EXP_VA));
    vecs.push_back(mk("a_idle",          1, 1, 1, 1, 1, EXP_IDLE));
    vecs.push_back(mk("a_idle_hold",     1, 1, 1, 1, 4, EXP_IDLE));

    rstn = 1'b0;
    clr_flt = 1'b0;
    apply_stimulus(0, 0, 0, 0);
    step(2);
    check_output("reset_outputs", EXP_IDLE);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].lo_a, vecs[i].hi_a, vecs[i].lo_b, vecs[i].hi_b);
      step(vecs[i].cycles);
      check_output(vecs[i].name, vecs[i].exp);
    end

    // Tank A between sensors, then glitches on lo_a.
    apply_stimulus(1, 0, 1, 1);
    step(6);
    check_output("a_midlevel_idle", EXP_IDLE);
    lo_a = 1'b0;
    step(3);
    lo_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_output("glitch3_ignored", EXP_IDLE);
    end
    lo_a = 1'b0;
    step(4);
    lo_a = 1'b1;
    step(1);
    check_output("glitch4_req", EXP_IDLE);
    step(1);
    check_output("glitch4_open_a", EXP_VA);
    step(3);
    check_output("glitch4_fill_a", EXP_FILL_A);

    // Fill timeout with hi_a never reached.
    step(49);
    check_output("timeout_last_motor", EXP_FILL_A);
    step(1);
    check_output("timeout_fault", EXP_F_TO);
    step(5);
    check_output("timeout_held", EXP_F_TO);
    apply_stimulus(1, 1, 1, 1);
    step(5);
    check_output("timeout_held_full", EXP_F_TO);
    pulse_clr();
    check_output("timeout_cleared", EXP_IDLE);
    step(4);
    check_output("timeout_no_regrant", EXP_IDLE);

    // Sensor B inconsistent: high covered, low dry.
    lo_b = 1'b0;
    step(4);
    check_output("sensor_b_debounce", EXP_IDLE);
    step(1);
    check_output("sensor_b_fault", EXP_F_SB);
    pulse_clr();
    check_output("sensor_b_clr_idle", EXP_IDLE);
    step(1);
    check_output("sensor_b_refault", EXP_F_SB);
    lo_b = 1'b1;
    step(5);
    check_output("sensor_b_held", EXP_F_SB);
    pulse_clr();
    check_output("sensor_b_cleared", EXP_IDLE);
    step(3);
    check_output("sensor_b_stays_idle", EXP_IDLE);

    // Reset in the middle of a tank B fill.
    apply_stimulus(1, 1, 0, 0);
    step(9);
    check_output("rst_fill_b", EXP_FILL_B);
    step(3);
    check_output("rst_fill_b_hold", EXP_FILL_B);
    rstn = 1'b0;
    apply_stimulus(0, 0, 0, 0);
    #1;
    check_output("rst_async_clear", EXP_IDLE);
    step(2);
    check_output("rst_held", EXP_IDLE);
    rstn = 1'b1;
    step(1);
    check_output("rst_req_latch", EXP_IDLE);
    step(1);
    check_output("rst_tie_grants_a", EXP_VA);
    step(2);
    check_output("rst_tie_open_a_hold", EXP_VA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
